sal_bank_ctrl: RTL

SAL_BANK_CTRL -- requirements
Module: sal_bank_ctrl

---
 rtl/sal_bank_ctrl.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/sal_bank_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sal_bank_ctrl
// Purpose  : Single-bank DRAM command sequencer. Holds one read/write
//            request, then offers ACT / RD / WR / PRE commands to a
//            scheduler. Five down-counters enforce the minimum spacing
//            between dependent commands.
// Ports    : clk, rst_n (sync, active-low)
//            req_valid_i / req_ready_o / req_wr_i / req_row_i / req_col_i
//              - request intake (one-entry holding register)
//            cmd_valid_o / cmd_ready_i / cmd_type_o / cmd_row_o / cmd_col_o
//              - command offer to scheduler (00 ACT, 01 RD, 10 WR, 11 PRE)
//            bank_open_o / open_row_o - open-row status
// Options  : SAL_BANK_CLOSE_PAGE_EN - close-page policy (PRE after every
//            RD/WR). Undefined: open-page policy.
// Revision : 1.0 - initial release
// ============================================================================
module sal_bank_ctrl #(
   parameter int CNTR_WIDTH = 4,
   parameter int ROW_WIDTH  = 14,
   parameter int COL_WIDTH  = 10,
   parameter int T_RCD      = 3,
   parameter int T_RP       = 3,
   parameter int T_RAS      = 8,
   parameter int T_RTP      = 2,
   parameter int T_WTP      = 6
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req_valid_i,
   output logic                 req_ready_o,
   input  logic                 req_wr_i,
   input  logic [ROW_WIDTH-1:0] req_row_i,
   input  logic [COL_WIDTH-1:0] req_col_i,
   output logic                 cmd_valid_o,
   input  logic                 cmd_ready_i,
   output logic [1:0]           cmd_type_o,
   output logic [ROW_WIDTH-1:0] cmd_row_o,
   output logic [COL_WIDTH-1:0] cmd_col_o,
   output logic                 bank_open_o,
   output logic [ROW_WIDTH-1:0] open_row_o
);

   localparam logic [1:0] c_st_closed  = 2'd0;
   localparam logic [1:0] c_st_open    = 2'd1;
`ifdef SAL_BANK_CLOSE_PAGE_EN
   localparam logic [1:0] c_st_closing = 2'd2;
`endif

   localparam logic [1:0] c_cmd_act = 2'b00;
   localparam logic [1:0] c_cmd_rd  = 2'b01;
   localparam logic [1:0] c_cmd_wr  = 2'b10;
   localparam logic [1:0] c_cmd_pre = 2'b11;

   // Counters load T-1 so that a command issued at cycle c unblocks its
   // dependant exactly at cycle c+T (counter reaches zero that cycle).
   localparam logic [CNTR_WIDTH-1:0] c_ld_rcd = CNTR_WIDTH'(T_RCD - 1);
   localparam logic [CNTR_WIDTH-1:0] c_ld_rp  = CNTR_WIDTH'(T_RP  - 1);
   localparam logic [CNTR_WIDTH-1:0] c_ld_ras = CNTR_WIDTH'(T_RAS - 1);
   localparam logic [CNTR_WIDTH-1:0] c_ld_rtp = CNTR_WIDTH'(T_RTP - 1);
   localparam logic [CNTR_WIDTH-1:0] c_ld_wtp = CNTR_WIDTH'(T_WTP - 1);
   localparam logic [CNTR_WIDTH-1:0] c_one    = CNTR_WIDTH'(1);
   localparam logic [CNTR_WIDTH-1:0] c_zero   = '0;

   logic [1:0]            r_state;
   logic                  r_held;
   logic                  r_wr;
   logic [ROW_WIDTH-1:0]  r_row;
   logic [COL_WIDTH-1:0]  r_col;
   logic [ROW_WIDTH-1:0]  r_open_row;
   logic [CNTR_WIDTH-1:0] r_cnt_rcd, r_cnt_rp, r_cnt_ras, r_cnt_rtp, r_cnt_wtp;

   logic                  w_valid;
   logic [1:0]            w_type;
   logic [ROW_WIDTH-1:0]  w_row;
   logic                  w_pre_ok;
   logic                  w_issue;
   logic                  w_capture;

   assign w_pre_ok  = (r_cnt_ras == c_zero) && (r_cnt_rtp == c_zero) &&
                      (r_cnt_wtp == c_zero);
   assign w_issue   = w_valid & cmd_ready_i;
   assign w_capture = req_valid_i & ~r_held;

   always_comb begin
      w_valid = 1'b0;
      w_type  = c_cmd_act;
      w_row   = r_open_row;
      case (r_state)
         c_st_closed: begin
            w_type  = c_cmd_act;
            w_row   = r_row;
            w_valid = r_held && (r_cnt_rp == c_zero);
         end
         c_st_open: begin
            if (r_row == r_open_row) begin
               w_type  = r_wr ? c_cmd_wr : c_cmd_rd;
               w_valid = r_held && (r_cnt_rcd == c_zero);
            end else begin
               w_type  = c_cmd_pre;
               w_valid = r_held && w_pre_ok;
            end
         end
`ifdef SAL_BANK_CLOSE_PAGE_EN
         // Precharge wins over any newly held request.
         c_st_closing: begin
            w_type  = c_cmd_pre;
            w_valid = w_pre_ok;
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= c_st_closed;
         r_held     <= 1'b0;
         r_wr       <= 1'b0;
         r_row      <= '0;
         r_col      <= '0;
         r_open_row <= '0;
         r_cnt_rcd  <= '0;
         r_cnt_rp   <= '0;
         r_cnt_ras  <= '0;
         r_cnt_rtp  <= '0;
         r_cnt_wtp  <= '0;
      end else begin
         // Saturating decrement; a load below overrides it.
         r_cnt_rcd <= (r_cnt_rcd != c_zero) ? r_cnt_rcd - c_one : c_zero;
         r_cnt_rp  <= (r_cnt_rp  != c_zero) ? r_cnt_rp  - c_one : c_zero;
         r_cnt_ras <= (r_cnt_ras != c_zero) ? r_cnt_ras - c_one : c_zero;
         r_cnt_rtp <= (r_cnt_rtp != c_zero) ? r_cnt_rtp - c_one : c_zero;
         r_cnt_wtp <= (r_cnt_wtp != c_zero) ? r_cnt_wtp - c_one : c_zero;

         if (w_capture) begin
            r_held <= 1'b1;
            r_wr   <= req_wr_i;
            r_row  <= req_row_i;
            r_col  <= req_col_i;
         end

         if (w_issue) begin
            case (w_type)
               c_cmd_act: begin
                  r_state    <= c_st_open;
                  r_open_row <= r_row;
                  r_cnt_rcd  <= c_ld_rcd;
                  r_cnt_ras  <= c_ld_ras;
               end
               c_cmd_rd: begin
                  r_held    <= 1'b0;
                  r_cnt_rtp <= c_ld_rtp;
`ifdef SAL_BANK_CLOSE_PAGE_EN
                  r_state   <= c_st_closing;
`endif
               end
               c_cmd_wr: begin
                  r_held    <= 1'b0;
                  r_cnt_wtp <= c_ld_wtp;
`ifdef SAL_BANK_CLOSE_PAGE_EN
                  r_state   <= c_st_closing;
`endif
               end
               default: begin
                  r_state  <= c_st_closed;
                  r_cnt_rp <= c_ld_rp;
               end
            endcase
         end
      end
   end

`ifdef SAL_BANK_CLOSE_PAGE_EN
   // A request can be captured while PRE is on offer; freeze the column
   // shown on the command bus until that PRE issues so the offer is stable.
   logic [COL_WIDTH-1:0] r_cmd_col;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cmd_col <= '0;
      end else if (w_capture && (!w_valid || w_issue)) begin
         r_cmd_col <= req_col_i;
      end else if (w_issue) begin
         r_cmd_col <= r_col;
      end
   end
   assign cmd_col_o = r_cmd_col;
`else
   assign cmd_col_o = r_col;
`endif

   assign req_ready_o = ~r_held;
   assign cmd_valid_o = w_valid;
   assign cmd_type_o  = w_type;
   assign cmd_row_o   = w_row;
   assign bank_open_o = (r_state != c_st_closed);
   assign open_row_o  = r_open_row;

endmodule
`default_nettype wire
